// File: rtl/sw_pkg.sv
// Shared constants for the three-switch debouncer: bit positions and counter sizing.
// Pure declarations, no timing or flow-control behaviour.
package sw_pkg;

  localparam int SW_A   = 0;
  localparam int SW_B   = 1;
  localparam int SW_SEL = 2;
  localparam int SW_N   = 3;

  // Smallest counter width w with 2^w >= stable_cnt (at least 1 bit).
  function automatic int min_cnt_w(input int stable_cnt);
    int w;
    w = 1;
    while ((64'(1) << w) < 64'(stable_cnt))
      w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: synchroniser, stability counter, stable level, rise/fall pulses.
// Latency SYNC_STAGES-1+STABLE_CNT edges from first sample; no backpressure, level input only.
module debounce_bit #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 50000,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   synced;
  logic [CNT_W-1:0]       cnt;

  assign synced = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      rise <= 1'b0;
      fall <= 1'b0;
      // Any return to the stable level drops all accumulated count.
      if (synced == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= synced;
        cnt    <= '0;
        rise   <= synced;
        fall   <= ~synced;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_debounce_3.sv
// Debounces the a/b/sel switches feeding the 2:1 selector; three independent bit lanes.
// Latency SYNC_STAGES-1+STABLE_CNT edges; registered outputs, no backpressure.
module sw_debounce_3
  import sw_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 50000,
  parameter int CNT_W       = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SW_N-1:0] sw_raw,
  output logic            a,
  output logic            b,
  output logic            sel,
  output logic [SW_N-1:0] rise,
  output logic [SW_N-1:0] fall
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("sw_debounce_3: SYNC_STAGES must be 2..4");
  end
  if (STABLE_CNT < 1) begin : g_bad_stable
    $error("sw_debounce_3: STABLE_CNT must be >= 1");
  end
  if (CNT_W < min_cnt_w(STABLE_CNT)) begin : g_bad_cnt_w
    $error("sw_debounce_3: CNT_W too narrow for STABLE_CNT");
  end

  logic [SW_N-1:0] level;

  for (genvar i = 0; i < SW_N; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_CNT  (STABLE_CNT),
      .CNT_W       (CNT_W)
    ) u_bit (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (sw_raw[i]),
      .stable (level[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  assign a   = level[SW_A];
  assign b   = level[SW_B];
  assign sel = level[SW_SEL];

endmodule

// File: tb/tb_sw_debounce_3.sv
// Directed bench for sw_debounce_3 (SYNC_STAGES=2, STABLE_CNT=4): expected pulses are queued
// when stimulus is driven and a negedge monitor matches each DUT pulse against the queue.
module tb_sw_debounce_3;

  // Drive point (just after edge T) -> E0 = edge T+1 -> output change at E5 = edge T+6.
  localparam int DLY = 6;

  typedef struct packed {
    int         cyc;
    logic [2:0] r;
    logic [2:0] f;
    logic [2:0] l;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] sw_raw;
  logic       a, b, sel;
  logic [2:0] rise, fall;

  int   cyc;
  int   n_chk;
  int   n_pass;
  exp_t exp_q[$];

  sw_debounce_3 #(
    .SYNC_STAGES (2),
    .STABLE_CNT  (4),
    .CNT_W       (3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_raw (sw_raw),
    .a      (a),
    .b      (b),
    .sel    (sel),
    .rise   (rise),
    .fall   (fall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act === exp)
      n_pass = n_pass + 1;
    else
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input logic [2:0] r, input logic [2:0] f, input logic [2:0] l);
    exp_t e;
    e.cyc = cyc + DLY;
    e.r   = r;
    e.f   = f;
    e.l   = l;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle with a pulse must match the next queued expectation.
  always @(negedge clk) begin
    if ((rise | fall) != 3'b000) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {26'd0, rise, fall}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_rise", {29'd0, rise}, {29'd0, e.r});
        chk("pulse_fall", {29'd0, fall}, {29'd0, e.f});
        chk("pulse_level", {29'd0, sel, b, a}, {29'd0, e.l});
      end
    end
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b1;
    sw_raw = 3'b111;
    #1 rst_n = 1'b0;

    // Reset held with all switches high: outputs must stay low.
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("reset_hold", {23'd0, sel, b, a, rise, fall}, 32'd0);
    end
    rst_n = 1'b1;
    expect_pulse(3'b111, 3'b000, 3'b111);
    tick(5);
    chk("reset_release_early", {29'd0, sel, b, a}, 32'd0);
    tick(10);

    // Simultaneous falls on all bits.
    sw_raw = 3'b000;
    expect_pulse(3'b000, 3'b111, 3'b000);
    tick(12);

    // Clean step on bit 0.
    sw_raw = 3'b001;
    expect_pulse(3'b001, 3'b000, 3'b001);
    tick(3);
    chk("step_a_mid", {31'd0, a}, 32'd0);
    tick(9);

    // Bounce on bit 1: 1,0,1,0 with 2-cycle widths, then hold 1.
    sw_raw = 3'b011; tick(2);
    chk("bounce_b_hold0", {31'd0, b}, 32'd0);
    sw_raw = 3'b001; tick(2);
    sw_raw = 3'b011; tick(2);
    chk("bounce_b_hold1", {31'd0, b}, 32'd0);
    sw_raw = 3'b001; tick(2);
    sw_raw = 3'b011;
    expect_pulse(3'b010, 3'b000, 3'b011);
    tick(3);
    chk("bounce_b_qualifying", {31'd0, b}, 32'd0);
    tick(9);

    // Glitch on sel: high for 3 cycles only.
    sw_raw = 3'b111; tick(3);
    sw_raw = 3'b011;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("glitch_sel", {31'd0, sel}, 32'd0);
    end
    tick(4);

    // Reset three cycles into qualification of a sel step.
    sw_raw = 3'b111;
    tick(5);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {23'd0, sel, b, a, rise, fall}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    expect_pulse(3'b111, 3'b000, 3'b111);
    tick(5);
    chk("midreset_requalify_early", {29'd0, sel, b, a}, 32'd0);
    tick(10);

    chk("pending_pulses", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
